// File: rtl/insn_fetch.sv
// Instruction fetch stage: single-outstanding memory reads feed a small prefetch
// FIFO of {addr, data} entries. Taken jumps flush and redirect; illegal words park.
`timescale 1ns/1ps
`ifndef RESETVECTOR
`define RESETVECTOR 32'h0000_0000
`endif

module insn_fetch #(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = `RESETVECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic        insn_valid,
    output logic [31:0] insn_data,
    output logic [31:0] insn_addr,
    input  logic        insn_ready,
    output logic        stalled
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_PARK} state_t;

    state_t           state, state_next;
    logic [31:0]      fetch_pc;
    logic [31:0]      drop_addr;
    logic [31:0]      fifo_data [DEPTH];
    logic [31:0]      fifo_addr [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic [31:0]      hold_data, hold_addr;
    logic             push, pop, illegal;

    assign illegal    = (mem_data[31:28] == 4'hF);
    assign push       = (state == S_REQ) && mem_ack && !redirect;
    assign pop        = insn_valid && insn_ready && !redirect;
    assign insn_valid = (count != '0);
    assign insn_data  = insn_valid ? fifo_data[rd_ptr] : hold_data;
    assign insn_addr  = insn_valid ? fifo_addr[rd_ptr] : hold_addr;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_next = count;
        if (redirect)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (!redirect && count < DEPTH_C) state_next = S_REQ;
            S_REQ: begin
                if (redirect)
                    state_next = mem_ack ? S_IDLE : S_DROP;
                else if (mem_ack) begin
                    if (illegal)
                        state_next = S_PARK;
                    else
                        state_next = (count_next < DEPTH_C) ? S_REQ : S_IDLE;
                end
            end
            S_DROP: if (mem_ack) state_next = S_IDLE;
            S_PARK: if (redirect) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = fetch_pc;
        stalled  = 1'b0;
        case (state)
            S_REQ:  mem_req = 1'b1;
            S_DROP: begin
                mem_req  = 1'b1;
                mem_addr = drop_addr;
            end
            S_PARK: stalled = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_VECTOR;
            drop_addr <= RESET_VECTOR;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            hold_data <= '0;
            hold_addr <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                rd_ptr   <= wr_ptr;
                // The in-flight request keeps its address until the stale ack returns.
                if (state == S_REQ && !mem_ack)
                    drop_addr <= fetch_pc;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    fetch_pc <= fetch_pc + 32'd1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
            if (insn_valid) begin
                hold_data <= fifo_data[rd_ptr];
                hold_addr <= fifo_addr[rd_ptr];
            end
        end
    end

    // NOTE: FIFO storage is not reset; reads are gated by insn_valid, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_data;
            fifo_addr[wr_ptr] <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: a reference model predicts the delivered instruction stream
// into a queue; an independent monitor pops and compares on every consume handshake.
`timescale 1ns/1ps

module tb_insn_fetch;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk, reset, redirect, mem_req, mem_ack, insn_valid, insn_ready, stalled;
    logic [31:0] redirect_pc, mem_addr, mem_data, insn_data, insn_addr;

    int          checks = 0;
    int          errors = 0;
    int          lat_lo = 0, lat_hi = 0, ill_mode = 0;
    logic [31:0] ill_addr = 32'h0;
    bit          mem_busy = 0;
    int          mem_wait = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t      exp_q[$];
    logic [31:0] exp_pc;
    bit          stale, parked, flushed;

    insn_fetch #(.DEPTH(4), .RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .insn_valid(insn_valid), .insn_data(insn_data), .insn_addr(insn_addr),
        .insn_ready(insn_ready), .stalled(stalled)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory contents: addr^A5A5 with the top nibble cleared, plus optional illegal words.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (ill_mode == 1 && a == ill_addr) return 32'hF000_0000;
        if (ill_mode == 2 && a[4:0] == 5'h13) return 32'hF000_0000 | {16'h0, a[15:0]};
        return (a ^ 32'h0000_A5A5) & 32'h0FFF_FFFF;
    endfunction

    // Instruction memory: answers each request after lat_lo..lat_hi wait cycles.
    initial begin
        mem_ack  = 0;
        mem_data = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || !mem_req) begin
                mem_ack  = 0;
                mem_busy = 0;
                mem_data = $urandom;
            end else begin
                if (!mem_busy) begin
                    mem_busy = 1;
                    mem_wait = $urandom_range(lat_hi, lat_lo);
                end
                if (mem_wait == 0) begin
                    mem_ack  = 1;
                    mem_data = mem_fn(mem_addr);
                    mem_busy = 0;
                end else begin
                    mem_ack  = 0;
                    mem_data = $urandom;
                    mem_wait--;
                end
            end
        end
    end

    // Reference model: sequential fetch from the last redirect target, stale acks
    // discarded, stream ends at the first illegal word until the next redirect.
    initial begin
        logic [31:0] d;
        entry_t      e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                exp_pc  = RV;
                stale   = 0;
                parked  = 0;
                flushed = 0;
            end else begin
                check("stalled", {31'h0, stalled}, {31'h0, parked});
                if (flushed) begin
                    check("flush_valid", {31'h0, insn_valid}, 32'h0);
                    flushed = 0;
                end
                if (parked) check("park_req", {31'h0, mem_req}, 32'h0);
                if (mem_req && mem_ack) begin
                    if (redirect || stale) begin
                        stale = 0;
                    end else begin
                        check("mem_addr", mem_addr, exp_pc);
                        d      = mem_fn(exp_pc);
                        e.addr = exp_pc;
                        e.data = d;
                        exp_q.push_back(e);
                        if (d[31:28] == 4'hF) parked = 1;
                        exp_pc = exp_pc + 32'd1;
                    end
                end else if (mem_req && redirect) begin
                    stale = 1;
                end
                if (redirect) begin
                    exp_q.delete();
                    exp_pc  = redirect_pc;
                    parked  = 0;
                    flushed = 1;
                end
            end
        end
    end

    // Monitor: every consume handshake must match the oldest predicted entry.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (!reset && insn_valid && insn_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual addr=%h data=%h expected=none", insn_addr, insn_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_addr", insn_addr, e.addr);
                    check("sb_data", insn_data, e.data);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1;
        redirect = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        @(posedge clk);
        #1;
        redirect    = 1;
        redirect_pc = pc;
        @(posedge clk);
        #1;
        redirect = 0;
    endtask

    task automatic expect_insn(input logic [31:0] a, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (insn_valid && insn_ready && !redirect) begin
                check("insn_addr", insn_addr, a);
                check("insn_data", insn_data, mem_fn(a));
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL insn_wait actual=timeout expected addr=%h", a);
    endtask

    initial begin
        int  acks;
        int  reqs;
        bit  seen;
        reset       = 1;
        redirect    = 0;
        redirect_pc = 0;
        insn_ready  = 1;

        // Reset values, release latency, back-to-back zero-wait stream.
        @(negedge clk);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, RV);
        check("rst_valid", {31'h0, insn_valid}, 32'h0);
        check("rst_data", insn_data, 32'h0);
        check("rst_addr", insn_addr, 32'h0);
        check("rst_stalled", {31'h0, stalled}, 32'h0);
        @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        check("req_before_edge", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        check("req_after_edge", {31'h0, mem_req}, 32'h1);
        check("first_addr", mem_addr, RV);
        expect_insn(32'h100, 1);
        check("data_100", insn_data, 32'h0000_A4A5);
        expect_insn(32'h101, 1);
        expect_insn(32'h102, 1);
        @(negedge clk);
        #2;
        reset = 1;
        #1;
        check("async_req_drop", {31'h0, mem_req}, 32'h0);

        // Core stalled: credit limits the stage to DEPTH accepted acks.
        insn_ready = 0;
        do_reset();
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req && mem_ack) acks++;
        end
        check("credit_acks", acks, 4);
        check("credit_req_low", {31'h0, mem_req}, 32'h0);
        @(posedge clk);
        #1;
        insn_ready = 1;
        expect_insn(32'h100, 1);
        expect_insn(32'h101, 1);
        expect_insn(32'h102, 1);
        expect_insn(32'h103, 1);
        expect_insn(32'h104, 4);

        // Slow memory, redirect while the request to 101 is in flight.
        lat_lo = 3;
        lat_hi = 3;
        do_reset();
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h101) seen = 1;
        end
        check("found_req_101", {31'h0, seen}, 32'h1);
        pulse_redirect(32'h2000);
        @(negedge clk);
        check("drop_valid", {31'h0, insn_valid}, 32'h0);
        check("drop_req", {31'h0, mem_req}, 32'h1);
        check("drop_addr_held", mem_addr, 32'h101);
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (mem_req && mem_ack) begin
                seen = 1;
                check("stale_ack_addr", mem_addr, 32'h101);
            end
        end
        check("stale_ack_seen", {31'h0, seen}, 32'h1);
        @(negedge clk);
        check("stale_not_pushed", {31'h0, insn_valid}, 32'h0);
        expect_insn(32'h2000, 20);

        // Redirect coincident with an ack and a pop.
        lat_lo = 0;
        lat_hi = 0;
        do_reset();
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        redirect    = 1;
        redirect_pc = 32'h3000;
        @(negedge clk);
        check("coincide_ack", {31'h0, mem_ack}, 32'h1);
        check("coincide_pop", {31'h0, insn_valid & insn_ready}, 32'h1);
        @(posedge clk);
        #1;
        redirect = 0;
        @(negedge clk);
        check("coincide_empty", {31'h0, insn_valid}, 32'h0);
        check("coincide_idle", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        check("coincide_req", {31'h0, mem_req}, 32'h1);
        check("coincide_addr", mem_addr, 32'h3000);
        expect_insn(32'h3000, 1);

        // Illegal word at 105 parks the stage until a redirect.
        ill_mode = 1;
        ill_addr = 32'h105;
        do_reset();
        expect_insn(32'h100, 4);
        for (int a = 32'h101; a <= 32'h105; a++) expect_insn(32'(a), 1);
        check("illegal_data", insn_data, 32'hF000_0000);
        check("illegal_stalled", {31'h0, stalled}, 32'h1);
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) reqs++;
        end
        check("park_no_req", reqs, 0);
        pulse_redirect(32'h0);
        @(negedge clk);
        check("unpark_stalled", {31'h0, stalled}, 32'h0);
        expect_insn(32'h0, 3);

        // Address wrap at the top of the space.
        ill_mode = 0;
        pulse_redirect(32'hFFFF_FFFE);
        expect_insn(32'hFFFF_FFFE, 6);
        expect_insn(32'hFFFF_FFFF, 1);
        expect_insn(32'h0000_0000, 1);

        // Random traffic: variable latency, backpressure, redirects, illegal words.
        lat_lo   = 0;
        lat_hi   = 3;
        ill_mode = 2;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            insn_ready = ($urandom_range(9, 0) < 7);
            redirect   = ($urandom_range(99, 0) < 4);
            case ($urandom_range(3, 0))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 | $urandom_range(15, 0);
                default: redirect_pc = $urandom_range(255, 0);
            endcase
        end
        @(posedge clk);
        #1;
        redirect   = 0;
        insn_ready = 1;
        repeat (40) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/insn_fetch.md
# insn_fetch

Instruction fetch stage placed directly upstream of the core's decode/execute datapath. It issues word reads to instruction memory through a single-outstanding request/acknowledge port. Fetched words are buffered together with their addresses in a small prefetch FIFO, and the FIFO head is presented to the core through a valid/ready handshake. Taken jumps flush and redirect the stage, and an illegal-opcode word (bits [31:28] == 4'b1111) parks the stage until the next redirect.

## Interface
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16
- RESET_VECTOR, `RESETVECTOR, first fetch address after reset
- clk  in  1  sole clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- redirect  in  1  core took a jump; flush and refetch
- redirect_pc  in  32  target word address, sampled when redirect=1
- mem_req  out  1  read request to instruction memory
- mem_addr  out  32  word address of the request; stable while mem_req=1
- mem_ack  in  1  request complete; mem_data valid this cycle
- mem_data  in  32  instruction word returned by memory
- insn_valid  out  1  FIFO head is valid
- insn_data  out  32  FIFO head instruction word
- insn_addr  out  32  word address of insn_data
- insn_ready  in  1  core consumes head this cycle
- stalled  out  1  stage parked on an illegal word

## Operation
- fetch_pc register: reset to RESET_VECTOR. Incremented by 1 on each accepted ack, wrapping from 32'hFFFFFFFF to 0. Loaded with redirect_pc on redirect.
- FIFO: DEPTH entries of {addr, data}, with read/write pointers and a count register ($clog2(DEPTH)+1 bits).
- Credit rule: a new request may start only when count + outstanding < DEPTH. Overflow is therefore impossible.
- FSM states:
  - IDLE: mem_req=0.
    - Goes to REQ when credit is available and no redirect is present.
    - On redirect: loads fetch_pc and stays in IDLE for this cycle.
  - REQ: mem_req=1, mem_addr=fetch_pc.
    - On mem_ack: push {fetch_pc, mem_data} and increment fetch_pc.
    - If the pushed word has [31:28]==4'hF, go to PARK. Otherwise go to REQ if credit remains after the push, else IDLE.
    - Redirect without ack: go to DROP; fetch_pc <= redirect_pc.
    - Redirect with ack in the same cycle: discard the data (no push), fetch_pc <= redirect_pc, go to IDLE.
  - DROP: mem_req=1 with the stale address held.
    - On mem_ack: discard the data and go to IDLE.
    - A further redirect in DROP only reloads fetch_pc.
  - PARK: mem_req=0, stalled=1. Buffered words still drain to the core. Only a redirect leaves PARK (to IDLE).
- Redirect also empties the FIFO (count <= 0, pointers equal). A pop in the same cycle is ignored; redirect wins.
- Pop: when insn_valid && insn_ready, the read pointer advances.
  - Push and pop in the same cycle leave count unchanged.
  - Pop while empty has no effect.
- insn_data/insn_addr are X-free: they hold the last head value when insn_valid=0.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_VECTOR, insn_valid=0, insn_data=0, insn_addr=0, stalled=0, state IDLE, count=0.
- Asserting reset mid-request drops mem_req immediately (asynchronous). Memory must tolerate an abandoned request.
- mem_req rises after the first rising edge following reset deassertion.
- The ack is sampled at edge N. The word is visible at the FIFO head (insn_valid=1) in cycle N+1 if the FIFO was empty, giving a 1-cycle fetch-to-issue latency.
- Back-to-back fetch: in REQ, an ack at edge N with credit remaining keeps mem_req high, with mem_addr=fetch_pc+1 from cycle N+1. Throughput is 1 word/cycle with a zero-wait memory.
- mem_addr must not change while mem_req=1 and mem_ack=0.
- Redirect is sampled at edge N. insn_valid=0 in cycle N+1. The first request to redirect_pc appears in cycle N+2 (from IDLE), or after the stale ack (from DROP).
- stalled rises in the cycle after the illegal word's ack and falls in the cycle after a redirect.

## Test plan
- Reset release, RESET_VECTOR=32'h100, zero-wait memory returning addr^32'hA5A5, insn_ready=1:
  - mem_req rises 1 cycle after release.
  - insn_addr sequence 100,101,102 on consecutive cycles.
  - insn_data = addr^32'hA5A5.
- insn_ready=0 with DEPTH=4:
  - Exactly 4 acks are accepted, then mem_req stays 0.
  - Raising insn_ready yields addresses 100..103 in order, and fetching resumes at 104.
- Memory with 3-cycle ack latency, redirect to 32'h2000 one cycle after request to 101:
  - The stale ack is dropped.
  - The FIFO is empty.
  - The next insn_addr is 2000 and no entry with address 101 ever appears.
- Redirect coincident with mem_ack and with a pop:
  - No push and no pop take effect.
  - count=0 next cycle.
  - The next request address is redirect_pc.
- Word 32'hF0000000 returned at address 105:
  - It is delivered to the core, and stalled=1.
  - No further mem_req occurs.
  - A redirect to 0 clears stalled and fetches address 0.
- fetch_pc at 32'hFFFFFFFF: consecutive insn_addr values are FFFFFFFF then 00000000.
